// File: rtl/dm_mem_arb.sv
// Round-robin arbiter sharing the single debug-memory port between NrPorts requesters.
// Grant is combinational in the request cycle; the one-hot response valid follows one cycle later.
module dm_mem_arb #(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrPorts-1:0]                  req_i,
    input  logic [NrPorts-1:0]                  we_i,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NrPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NrPorts-1:0]                  gnt_o,
    output logic [NrPorts-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [BeWidth-1:0]                  mem_be_o,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int unsigned PtrW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    logic [PtrW-1:0]    r_rr_ptr;
    logic [NrPorts-1:0] r_rvalid;
    logic [PtrW-1:0]    w_win;
    logic [PtrW-1:0]    w_cand;
    logic               w_found;
    logic [NrPorts-1:0] w_gnt;
    int unsigned        w_sum;

    // Scan starting at the pointer; the first requester found wins the slot.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        w_sum   = 0;
        w_gnt   = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            w_sum  = (32'(r_rr_ptr) + i) % NrPorts;
            w_cand = w_sum[PtrW-1:0];
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        if (w_found) w_gnt[w_win] = 1'b1;
    end

    assign gnt_o       = w_gnt;
    assign mem_req_o   = w_found;
    assign mem_we_o    = w_found ? we_i[w_win]    : 1'b0;
    assign mem_addr_o  = w_found ? addr_i[w_win]  : '0;
    assign mem_wdata_o = w_found ? wdata_i[w_win] : '0;
    assign mem_be_o    = w_found ? be_i[w_win]    : '0;

    // Memory answers exactly one cycle after the request, so data passes straight through.
    assign rdata_o  = mem_rdata_i;
    assign rvalid_o = r_rvalid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_found)
                r_rr_ptr <= (32'(w_win) == NrPorts - 1) ? '0 : w_win + 1'b1;
        end
    end

    a_gnt_onehot:    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
    a_gnt_has_req:   assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
    a_mem_req:       assert property (@(posedge clk_i) disable iff (!rst_ni) mem_req_o == (|gnt_o));

endmodule
